multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Control FSM for a multi-cycle RV32I datapath: FETCH/DECODE/EXEC/MEM/WB with a memory-wait watchdog.
// Define MCU_ILLEGAL_TRAP_EN to send unrecognised opcodes to FAULT instead of executing them as NOPs.
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src1,
    output logic        alu_src2,
    output logic [3:0]  alu_type,
    output logic [1:0]  reg_src,
    output logic        reg_write_enable,
    output logic [2:0]  ls_type,
    output logic [2:0]  state,
    output logic        fault
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;
    localparam logic [1:0] REG_ALU  = 2'b00;
    localparam logic [1:0] REG_MEM  = 2'b01;
    localparam logic [1:0] REG_IMM  = 2'b10;
    localparam logic [1:0] REG_PC4  = 2'b11;

    // The watchdog fires when a request has gone MEM_WAIT_MAX cycles without an ack.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_WAIT_MAX - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_r, is_i, is_s, is_l, is_b, is_lui, is_auipc, is_jal, is_jalr;
    logic             legal;
    logic             waiting;
    logic             wait_expired;
    logic             unused_instr_bits;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_s     = (opcode == OP_S);
    assign is_l     = (opcode == OP_L);
    assign is_b     = (opcode == OP_B);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign legal    = is_r | is_i | is_s | is_l | is_b | is_lui | is_auipc | is_jal | is_jalr;

    assign waiting      = ((cur_state == ST_FETCH) || (cur_state == ST_MEM)) && !mem_ack;
    assign wait_expired = waiting && (wait_cnt == LAST_WAIT);

    assign ls_type = funct3;
    assign state   = cur_state;
    assign fault   = (cur_state == ST_FAULT);

    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_FETCH;
            wait_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_FETCH: begin
                if (mem_ack) begin
                    nxt_state = ST_DECODE;
                end else if (wait_expired) begin
                    nxt_state = ST_FAULT;
                end
            end
            ST_DECODE: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                nxt_state = legal ? ST_EXEC : ST_FAULT;
`else
                nxt_state = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                if (is_l || is_s) begin
                    nxt_state = ST_MEM;
                end else if (is_b || !legal) begin
                    nxt_state = ST_FETCH;
                end else begin
                    nxt_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    nxt_state = is_l ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    nxt_state = ST_FAULT;
                end
            end
            ST_WB:    nxt_state = ST_FETCH;
            ST_FAULT: nxt_state = ST_FAULT;
            default:  nxt_state = ST_FAULT;
        endcase
    end

    // Strobes come from the registered state; mem_ack only qualifies the completion pulses.
    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = PC_PLUS4;
        alu_src1         = 1'b0;
        alu_src2         = 1'b0;
        alu_type         = 4'd0;
        reg_src          = REG_ALU;
        reg_write_enable = 1'b0;
        if (!rst) begin
            if (cur_state inside {ST_EXEC, ST_MEM, ST_WB}) begin
                alu_src1 = is_b | is_auipc | is_jal;
                alu_src2 = legal & !is_r;
                if (is_r) begin
                    alu_type = {instr[30], funct3};
                end else if (is_i) begin
                    alu_type = {(funct3 == 3'b101) & instr[30], funct3};
                end
            end
            case (cur_state)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ack;
                end
                ST_EXEC: begin
                    if (is_b) begin
                        pc_write = 1'b1;
                        pc_src   = br_taken ? PC_REL : PC_PLUS4;
                    end else if (!legal) begin
                        pc_write = 1'b1;
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_we   = is_s;
                    pc_write = is_s & mem_ack;
                end
                ST_WB: begin
                    reg_write_enable = 1'b1;
                    pc_write         = 1'b1;
                    if (is_jal) begin
                        pc_src = PC_REL;
                    end else if (is_jalr) begin
                        pc_src = PC_REG;
                    end
                    if (is_l) begin
                        reg_src = REG_MEM;
                    end else if (is_lui) begin
                        reg_src = REG_IMM;
                    end else if (is_jal || is_jalr) begin
                        reg_src = REG_PC4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table, corner-case sequences and a random run
// against an instruction-level reference model.
module tb_multicycle_control_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ack;
    logic        br_taken;
    logic        mem_req, mem_we, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        alu_src1, alu_src2;
    logic [3:0]  alu_type;
    logic [1:0]  reg_src;
    logic        reg_write_enable;
    logic [2:0]  ls_type;
    logic [2:0]  state;
    logic        fault;

    int errors = 0;
    int checks = 0;

    multicycle_control_unit #(.MEM_WAIT_MAX(MAX_WAIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ack(mem_ack), .br_taken(br_taken),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_type(alu_type),
        .reg_src(reg_src), .reg_write_enable(reg_write_enable), .ls_type(ls_type),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef enum int {K_R, K_I, K_S, K_L, K_B, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BAD} kind_t;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, irw, pcw;
        logic [1:0] pcs;
        logic       rwe;
        logic [1:0] rs;
        logic       a1, a2;
        logic [3:0] at;
        logic [2:0] lt;
        logic       flt;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        tk;
        int          fdel;
        int          mdel;
        string       trace;
        int          n_rwe;
        int          n_pcw;
        logic [1:0]  pcs;
        logic [1:0]  rs;
        logic        flt;
    } vec_t;

    function automatic kind_t kind_of(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0100011: return K_S;
            7'b0000011: return K_L;
            7'b1100011: return K_B;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.st = state; o.req = mem_req; o.we = mem_we; o.irw = ir_write; o.pcw = pc_write;
        o.pcs = pc_src; o.rwe = reg_write_enable; o.rs = reg_src; o.a1 = alu_src1;
        o.a2 = alu_src2; o.at = alu_type; o.lt = ls_type; o.flt = fault;
        return o;
    endfunction

    // Quiet expectation for a phase: no strobes, ls_type follows funct3, fault only in phase 5.
    function automatic obs_t idle(input logic [31:0] ins, input logic [2:0] st);
        obs_t e;
        e     = '0;
        e.st  = st;
        e.lt  = ins[14:12];
        e.flt = (st == 3'd5);
        return e;
    endfunction

    function automatic obs_t with_alu(input obs_t e0, input logic [31:0] ins);
        obs_t  e = e0;
        kind_t k = kind_of(ins);
        e.a1 = (k == K_B) || (k == K_AUIPC) || (k == K_JAL);
        e.a2 = !((k == K_R) || (k == K_BAD));
        if (k == K_R) e.at = {ins[30], ins[14:12]};
        else if (k == K_I) e.at = {(ins[14:12] == 3'b101) && ins[30], ins[14:12]};
        return e;
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] ins, input logic tk,
                                input int fd, input int md, input string tr, input int rw,
                                input int pw, input logic [1:0] pcs, input logic [1:0] rs,
                                input logic flt);
        vec_t v;
        v.name = n; v.ins = ins; v.tk = tk; v.fdel = fd; v.mdel = md; v.trace = tr;
        v.n_rwe = rw; v.n_pcw = pw; v.pcs = pcs; v.rs = rs; v.flt = flt;
        return v;
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic cmp(input obs_t e, input string tag);
        obs_t got = sample_dut();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     tag, got, e, got.st, e.st);
        end
    endtask

    // Every step starts 1 time unit after a rising edge and ends at the same point one cycle later.
    task automatic step(input obs_t e, input logic ack, input logic tk, input string tag);
        mem_ack  = ack;
        br_taken = tk;
        @(negedge clk);
        cmp(e, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        mem_ack = 1'b0;
        #1;
        cmp(idle(instr, 3'd0), "reset outputs");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fault_tail(input logic [31:0] ins);
        for (int i = 0; i < 3; i++) step(idle(ins, 3'd5), rnd_bit(), rnd_bit(), "fault hold");
    endtask

    // Reference model: walks one instruction through its phases. Ack arrives after fdel/mdel idle
    // cycles; a request left unanswered for MAX_WAIT cycles ends in the fault state.
    task automatic model_instr(input logic [31:0] ins, input int fdel, input int mdel,
                               output logic faulted);
        kind_t k = kind_of(ins);
        obs_t  e;
        logic  tk;
        logic  acked = 1'b0;
        instr   = ins;
        faulted = 1'b0;
        for (int c = 0; c < MAX_WAIT && !acked; c++) begin
            e = idle(ins, 3'd0);
            e.req = 1'b1;
            if (c == fdel) begin
                e.irw = 1'b1;
                acked = 1'b1;
            end
            step(e, acked, rnd_bit(), "fetch");
        end
        if (!acked) begin
            fault_tail(ins);
            faulted = 1'b1;
            return;
        end
        step(idle(ins, 3'd1), rnd_bit(), rnd_bit(), "decode");
`ifdef MCU_ILLEGAL_TRAP_EN
        if (k == K_BAD) begin
            fault_tail(ins);
            faulted = 1'b1;
            return;
        end
`endif
        tk = rnd_bit();
        e  = with_alu(idle(ins, 3'd2), ins);
        if (k == K_B) begin
            e.pcw = 1'b1;
            e.pcs = {1'b0, tk};
        end
        if (k == K_BAD) e.pcw = 1'b1;
        step(e, rnd_bit(), tk, "exec");
        if (k == K_B || k == K_BAD) return;
        if (k == K_L || k == K_S) begin
            acked = 1'b0;
            for (int c = 0; c < MAX_WAIT && !acked; c++) begin
                e = with_alu(idle(ins, 3'd3), ins);
                e.req = 1'b1;
                e.we  = (k == K_S);
                if (c == mdel) begin
                    acked = 1'b1;
                    e.pcw = (k == K_S);
                end
                step(e, acked, rnd_bit(), "mem");
            end
            if (!acked) begin
                fault_tail(ins);
                faulted = 1'b1;
                return;
            end
            if (k == K_S) return;
        end
        e = with_alu(idle(ins, 3'd4), ins);
        e.rwe = 1'b1;
        e.pcw = 1'b1;
        e.pcs = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
        e.rs  = (k == K_L) ? 2'd1 : (k == K_LUI) ? 2'd2 : (k == K_JAL || k == K_JALR) ? 2'd3 : 2'd0;
        step(e, rnd_bit(), rnd_bit(), "writeback");
    endtask

    // Runs one table vector until the unit returns to fetch or faults; ack is held high outside
    // the fetch and memory phases to show it is ignored there.
    task automatic applyStimulus(input vec_t v, output string tr, output int nrwe, output int npcw,
                                 output logic [1:0] pcs, output logic [1:0] rs, output logic flt,
                                 output logic done);
        logic [2:0] st;
        logic       left = 1'b0;
        int         fw = 0;
        int         mw = 0;
        tr = ""; nrwe = 0; npcw = 0; pcs = 2'd0; rs = 2'd0; flt = 1'b0; done = 1'b0;
        instr = v.ins;
        for (int c = 0; c < 40 && !done; c++) begin
            st = state;
            if (left && st == 3'd0) begin
                done = 1'b1;
            end else begin
                mem_ack  = (st == 3'd0) ? (fw == v.fdel) : (st == 3'd3) ? (mw == v.mdel) : 1'b1;
                br_taken = v.tk;
                @(negedge clk);
                tr = {tr, $sformatf("%0d", state)};
                if (reg_write_enable) begin nrwe++; rs = reg_src; end
                if (pc_write) begin npcw++; pcs = pc_src; end
                flt = fault;
                @(posedge clk);
                #1;
                if (st == 3'd0) fw++; else left = 1'b1;
                if (st == 3'd3) mw++;
                if (st == 3'd5) done = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input vec_t v, input string tr, input int nrwe, input int npcw,
                               input logic [1:0] pcs, input logic [1:0] rs, input logic flt,
                               input logic done);
        check_val({v.name, " completes"}, int'(done), 1);
        check_str({v.name, " states"}, tr, v.trace);
        check_val({v.name, " reg writes"}, nrwe, v.n_rwe);
        check_val({v.name, " pc writes"}, npcw, v.n_pcw);
        check_val({v.name, " pc_src"}, int'(pcs), int'(v.pcs));
        check_val({v.name, " reg_src"}, int'(rs), int'(v.rs));
        check_val({v.name, " fault"}, int'(flt), int'(v.flt));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[12];
        string       tr;
        int          nrwe, npcw, fdel, mdel;
        logic [1:0]  pcs, rs;
        logic        flt, done, faulted;
        logic [31:0] r, sw_ins;
        logic [6:0]  ops[10];

        vecs[0]  = mk("add",       32'h002081B3, 1'b0, 0, 0, "0124", 1, 1, 2'd0, 2'd0, 1'b0);
        vecs[1]  = mk("lw mem+3",  32'h0000A283, 1'b0, 0, 3, "01233334", 1, 1, 2'd0, 2'd1, 1'b0);
        vecs[2]  = mk("sw",        32'h0020A023, 1'b0, 0, 0, "0123", 0, 1, 2'd0, 2'd0, 1'b0);
        vecs[3]  = mk("beq taken", 32'h00208463, 1'b1, 0, 0, "012", 0, 1, 2'd1, 2'd0, 1'b0);
        vecs[4]  = mk("beq not",   32'h00208463, 1'b0, 0, 0, "012", 0, 1, 2'd0, 2'd0, 1'b0);
        vecs[5]  = mk("lui",       32'h123450B7, 1'b0, 0, 0, "0124", 1, 1, 2'd0, 2'd2, 1'b0);
        vecs[6]  = mk("auipc",     32'h00001097, 1'b0, 0, 0, "0124", 1, 1, 2'd0, 2'd0, 1'b0);
        vecs[7]  = mk("jal",       32'h010000EF, 1'b0, 0, 0, "0124", 1, 1, 2'd1, 2'd3, 1'b0);
        vecs[8]  = mk("jalr",      32'h00008067, 1'b0, 0, 0, "0124", 1, 1, 2'd2, 2'd3, 1'b0);
        vecs[9]  = mk("addi late ack", 32'h00500093, 1'b0, MAX_WAIT - 1, 0,
                      "000000000000000124", 1, 1, 2'd0, 2'd0, 1'b0);
        vecs[10] = mk("lw fetch+2", 32'h0000A283, 1'b0, 2, 0, "0001234", 1, 1, 2'd0, 2'd1, 1'b0);
`ifdef MCU_ILLEGAL_TRAP_EN
        vecs[11] = mk("opcode 7f", 32'h0000007F, 1'b0, 0, 0, "015", 0, 0, 2'd0, 2'd0, 1'b1);
`else
        vecs[11] = mk("opcode 7f", 32'h0000007F, 1'b0, 0, 0, "012", 0, 1, 2'd0, 2'd0, 1'b0);
`endif

        instr = 32'h0; mem_ack = 1'b0; br_taken = 1'b0; rst = 1'b1;
        do_reset();

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], tr, nrwe, npcw, pcs, rs, flt, done);
            checkOutput(vecs[i], tr, nrwe, npcw, pcs, rs, flt, done);
            if (vecs[i].flt || flt || !done) do_reset();
        end

        $display("[TB] watchdog corners");
        model_instr(32'h002081B3, MAX_WAIT, 0, faulted);
        do_reset();
        model_instr(32'h0000A283, 0, MAX_WAIT - 1, faulted);
        if (faulted) do_reset();
        model_instr(32'h0000A283, 0, MAX_WAIT, faulted);
        do_reset();

        $display("[TB] reset during store");
        sw_ins = 32'h0020A023;
        instr  = sw_ins;
        begin
            obs_t e;
            e = idle(sw_ins, 3'd0);
            e.req = 1'b1;
            e.irw = 1'b1;
            step(e, 1'b1, 1'b0, "sw fetch");
            step(idle(sw_ins, 3'd1), 1'b0, 1'b0, "sw decode");
            step(with_alu(idle(sw_ins, 3'd2), sw_ins), 1'b0, 1'b0, "sw exec");
        end
        mem_ack = 1'b0;
        @(negedge clk);
        check_val("sw in mem state", int'(state), 3);
        check_val("sw in mem we", int'(mem_we), 1);
        #2 rst = 1'b1;
        #1;
        check_val("async reset state", int'(state), 0);
        check_val("async reset mem_req", int'(mem_req), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("refetch state", int'(state), 0);
        check_val("refetch mem_req", int'(mem_req), 1);
        check_val("refetch mem_we", int'(mem_we), 0);
        @(posedge clk);
        #1;
        do_reset();

        $display("[TB] random instructions");
        ops = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        for (int i = 0; i < 80; i++) begin
            r    = $urandom();
            fdel = ($urandom_range(0, 19) == 0) ? MAX_WAIT : int'($urandom_range(0, 3));
            mdel = ($urandom_range(0, 19) == 0) ? MAX_WAIT : int'($urandom_range(0, 3));
            model_instr({r[31:7], ops[$urandom_range(0, 9)]}, fdel, mdel, faulted);
            if (faulted) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
